data_mem_resp: RTL and testbench

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/mem_resp_pkg.sv | 33 +++
 rtl/mem_lane_align.sv | 55 +++++
 rtl/data_mem_resp.sv | 162 ++++++++++++++++
 tb/tb_data_mem_resp.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and defaults for the data memory responder.
// The misalignment rule lives here so the FSM and any checkers agree on it.
package mem_resp_pkg;

  localparam int unsigned DEFAULT_DEPTH   = 256;
  localparam int unsigned DEFAULT_LATENCY = 2;

  typedef enum logic [1:0] {
    BYTE   = 2'b00,
    HALF   = 2'b01,
    WORD   = 2'b10,
    DOUBLE = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  function automatic logic misaligned(input size_e sz, input logic [2:0] lane);
    logic res;
    case (sz)
      BYTE:    res = 1'b0;
      HALF:    res = lane[0];
      WORD:    res = |lane[1:0];
      DOUBLE:  res = |lane;
      default: res = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: load extraction with sign/zero extension
// and store merge of the addressed bytes into the existing doubleword.
module mem_lane_align
  import mem_resp_pkg::*;
(
  input  size_e       size_i,
  input  logic        unsigned_i,
  input  logic [2:0]  lane_i,
  input  logic [63:0] word_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] rdata_o,
  output logic [63:0] merged_o
);

  logic [5:0]  shamt_s;
  logic [63:0] shifted_s;
  logic [63:0] mask_s;

  assign shamt_s   = {lane_i, 3'b000};
  assign shifted_s = word_i >> shamt_s;

  // Size-dependent mask and extension of the right-aligned load data.
  always_comb begin
    mask_s  = 64'hFFFF_FFFF_FFFF_FFFF;
    rdata_o = shifted_s;
    case (size_i)
      BYTE: begin
        mask_s  = 64'h0000_0000_0000_00FF;
        rdata_o = unsigned_i ? {56'd0, shifted_s[7:0]}
                             : {{56{shifted_s[7]}}, shifted_s[7:0]};
      end
      HALF: begin
        mask_s  = 64'h0000_0000_0000_FFFF;
        rdata_o = unsigned_i ? {48'd0, shifted_s[15:0]}
                             : {{48{shifted_s[15]}}, shifted_s[15:0]};
      end
      WORD: begin
        mask_s  = 64'h0000_0000_FFFF_FFFF;
        rdata_o = unsigned_i ? {32'd0, shifted_s[31:0]}
                             : {{32{shifted_s[31]}}, shifted_s[31:0]};
      end
      DOUBLE: begin
        mask_s  = 64'hFFFF_FFFF_FFFF_FFFF;
        rdata_o = shifted_s;
      end
      default: begin
        mask_s  = 64'h0000_0000_0000_0000;
        rdata_o = 64'h0000_0000_0000_0000;
      end
    endcase
  end

  assign merged_o = (word_i & ~(mask_s << shamt_s)) | ((wdata_i & mask_s) << shamt_s);

endmodule

// File: rtl/data_mem_resp.sv
// Single-port doubleword data memory with a fixed-latency valid/ready
// request/response handshake and misalignment/range error reporting.
module data_mem_resp
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH   = DEFAULT_DEPTH,
  parameter int unsigned LATENCY = DEFAULT_LATENCY
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        write_q, unsigned_q;
  size_e       size_q;
  logic [63:0] addr_q, wdata_q;
  logic [63:0] mem_q [DEPTH];

  logic             accept_s, do_access_s, err_s, wr_en_s;
  logic             cur_write_s, cur_unsigned_s;
  size_e            cur_size_s;
  logic [63:0]      cur_addr_s, cur_wdata_s, load_s, merged_s;
  logic [IDX_W-1:0] idx_s;

  assign accept_s = (state_q == IDLE) && req_valid_i;

  // With zero latency the access happens on the acceptance edge, so the live inputs are used.
  assign cur_write_s    = (state_q == IDLE) ? req_write_i           : write_q;
  assign cur_size_s     = (state_q == IDLE) ? size_e'(req_size_i)   : size_q;
  assign cur_unsigned_s = (state_q == IDLE) ? req_unsigned_i        : unsigned_q;
  assign cur_addr_s     = (state_q == IDLE) ? req_addr_i            : addr_q;
  assign cur_wdata_s    = (state_q == IDLE) ? req_wdata_i           : wdata_q;

  assign idx_s   = cur_addr_s[IDX_W+2:3];
  assign err_s   = (|cur_addr_s[63:IDX_W+3]) || misaligned(cur_size_s, cur_addr_s[2:0]);
  assign wr_en_s = do_access_s && cur_write_s && !err_s && rst_ni;

  mem_lane_align u_lane (
    .size_i     (cur_size_s),
    .unsigned_i (cur_unsigned_s),
    .lane_i     (cur_addr_s[2:0]),
    .word_i     (mem_q[idx_s]),
    .wdata_i    (cur_wdata_s),
    .rdata_o    (load_s),
    .merged_o   (merged_s)
  );

  // Next-state, latency counter and response data.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    do_access_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (LAT == 4'd0) begin
            do_access_s = 1'b1;
            state_d     = RESP;
            cnt_d       = 4'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          do_access_s = 1'b1;
          state_d     = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
          rdata_d = 64'd0;
          err_d   = 1'b0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (do_access_s) begin
      err_d   = err_s;
      rdata_d = (err_s || cur_write_s) ? 64'd0 : load_s;
    end else begin
      err_d = err_d;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request capture, frozen for the rest of the transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      write_q    <= 1'b0;
      size_q     <= BYTE;
      unsigned_q <= 1'b0;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
    end else if (accept_s) begin
      write_q    <= req_write_i;
      size_q     <= size_e'(req_size_i);
      unsigned_q <= req_unsigned_i;
      addr_q     <= req_addr_i;
      wdata_q    <= req_wdata_i;
    end
  end

  // Storage deliberately has no reset so contents survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[idx_s] <= merged_s;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Randomised bench for data_mem_resp against a byte-array reference model;
// a second zero-latency instance covers the LATENCY=0 path.
module tb_data_mem_resp;

  localparam int DEPTH  = 256;
  localparam int LAT    = 2;
  localparam int DEPTH0 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  logic        req_valid0, req_ready0, req_write0, req_unsigned0;
  logic [1:0]  req_size0;
  logic [63:0] req_addr0, req_wdata0;
  logic        rsp_valid0, rsp_ready0, rsp_err0;
  logic [63:0] rsp_rdata0;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] mem_m [DEPTH*8];

  data_mem_resp #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  data_mem_resp #(.DEPTH(DEPTH0), .LATENCY(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_write_i(req_write0),
    .req_size_i(req_size0), .req_unsigned_i(req_unsigned0), .req_addr_i(req_addr0),
    .req_wdata_i(req_wdata0), .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0),
    .rsp_rdata_o(rsp_rdata0), .rsp_err_o(rsp_err0)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain byte array, little-endian, errors from the size/range rules.
  function automatic void model_access(input logic w, input logic [1:0] sz, input logic u,
                                       input logic [63:0] a, input logic [63:0] wd,
                                       output logic [63:0] rd, output logic e);
    int n;
    int base;
    n    = 1 << sz;
    e    = ((a % 64'(n)) != 64'd0) || (a[63:3] >= 61'(DEPTH));
    rd   = 64'd0;
    base = 0;
    if (!e) begin
      base = int'(a[31:0]);
      if (w) begin
        for (int k = 0; k < n; k++) mem_m[base+k] = wd[8*k +: 8];
      end else begin
        for (int k = 0; k < n; k++) rd[8*k +: 8] = mem_m[base+k];
        if (!u && n < 8 && rd[8*n-1]) begin
          for (int k = n; k < 8; k++) rd[8*k +: 8] = 8'hFF;
        end
      end
    end
  endfunction

  task automatic junk();
    req_valid    = 1'($urandom_range(0, 1));
    req_write    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = {$urandom, $urandom};
    req_wdata    = {$urandom, $urandom};
  endtask

  task automatic run(input logic w, input logic [1:0] sz, input logic u, input logic [63:0] a,
                     input logic [63:0] wd, input int hold,
                     output logic [63:0] got, output logic got_err);
    logic [63:0] exp_rd;
    logic        exp_e;
    int          n;
    model_access(w, sz, u, a, wd, exp_rd, exp_e);
    check_eq("idle_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd; rsp_ready = 1'b0;
    @(posedge clk); #1;
    n = 0;
    while (!rsp_valid && n < 40) begin
      check_eq("busy_ready", 64'(req_ready), 64'd0);
      junk();
      @(posedge clk); #1;
      n++;
    end
    check_eq("latency", 64'(n), 64'(LAT));
    for (int h = 0; h < hold; h++) begin
      check_eq("hold_valid", 64'(rsp_valid), 64'd1);
      check_eq("hold_rdata", rsp_rdata, exp_rd);
      junk();
      @(posedge clk); #1;
    end
    got     = rsp_rdata;
    got_err = rsp_err;
    check_eq("rsp_valid", 64'(rsp_valid), 64'd1);
    check_eq("rsp_rdata", rsp_rdata, exp_rd);
    check_eq("rsp_err", 64'(rsp_err), 64'(exp_e));
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq("post_valid", 64'(rsp_valid), 64'd0);
    check_eq("post_ready", 64'(req_ready), 64'd1);
  endtask

  task automatic run0(input logic w, input logic [1:0] sz, input logic u, input logic [63:0] a,
                      input logic [63:0] wd, input logic [63:0] exp_rd, input logic exp_e);
    req_valid0 = 1'b1; req_write0 = w; req_size0 = sz; req_unsigned0 = u;
    req_addr0 = a; req_wdata0 = wd;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    check_eq("lat0_valid", 64'(rsp_valid0), 64'd1);
    check_eq("lat0_rdata", rsp_rdata0, exp_rd);
    check_eq("lat0_err", 64'(rsp_err0), 64'(exp_e));
    rsp_ready0 = 1'b1;
    @(posedge clk); #1;
    rsp_ready0 = 1'b0;
    check_eq("lat0_idle", 64'(req_ready0), 64'd1);
  endtask

  initial begin
    logic [63:0] g;
    logic        e;
    logic [63:0] a;
    logic        w, u;
    logic [1:0]  sz;
    int          r;

    rst_n = 1'b0; rsp_ready = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
    req_valid0 = 1'b0; req_write0 = 1'b0; req_size0 = 2'd0; req_unsigned0 = 1'b0;
    req_addr0 = 64'd0; req_wdata0 = 64'd0; rsp_ready0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 64'(req_ready), 64'd1);
    check_eq("rst_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_rdata", rsp_rdata, 64'd0);
    check_eq("rst_err", 64'(rsp_err), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < DEPTH; i++) run(1'b1, 2'd3, 1'b0, 64'(i*8), {$urandom, $urandom}, 0, g, e);

    run(1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788, 0, g, e);
    run(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 0, g, e);
    check_eq("ld_double", g, 64'h1122334455667788);
    check_eq("ld_double_err", 64'(e), 64'd0);
    run(1'b0, 2'd0, 1'b0, 64'h17, 64'd0, 0, g, e);
    check_eq("ld_byte_17", g, 64'h0000000000000011);
    run(1'b1, 2'd0, 1'b0, 64'h10, 64'h00000000000000FF, 0, g, e);
    run(1'b0, 2'd0, 1'b0, 64'h10, 64'd0, 5, g, e);
    check_eq("ld_byte_sx", g, 64'hFFFFFFFFFFFFFFFF);
    run(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 0, g, e);
    check_eq("merge", g, 64'h11223344556677FF);
    run(1'b0, 2'd2, 1'b1, 64'h12, 64'd0, 0, g, e);
    check_eq("misal_err", 64'(e), 64'd1);
    check_eq("misal_rdata", g, 64'd0);
    run(1'b0, 2'd3, 1'b0, 64'(DEPTH*8), 64'd0, 0, g, e);
    check_eq("range_err", 64'(e), 64'd1);
    run(1'b1, 2'd1, 1'b0, 64'h11, 64'hDEAD, 0, g, e);
    check_eq("st_misal_err", 64'(e), 64'd1);
    run(1'b1, 2'd3, 1'b0, 64'(DEPTH*8), 64'hDEAD, 0, g, e);
    run(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 0, g, e);
    check_eq("mem_unchanged", g, 64'h11223344556677FF);

    run(1'b1, 2'd3, 1'b0, 64'h20, 64'h0000000000000055, 0, g, e);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 64'h20; req_wdata = 64'h00000000000000AA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", 64'(req_ready), 64'd1);
    check_eq("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check_eq("mid_rst_err", 64'(rsp_err), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("no_rsp_after_rst", 64'(rsp_valid), 64'd0);
    end
    run(1'b0, 2'd0, 1'b1, 64'h20, 64'd0, 0, g, e);
    check_eq("aborted_store", g, 64'h0000000000000055);

    for (int t = 0; t < 400; t++) begin
      w  = 1'($urandom);
      u  = 1'($urandom);
      sz = 2'($urandom);
      r  = $urandom_range(0, 9);
      if (r == 0) a = {$urandom, $urandom};
      else if (r == 1) a = 64'(DEPTH*8 + $urandom_range(0, 63));
      else a = 64'($urandom_range(0, DEPTH*8-1));
      if (r > 4) a = a & ~64'((1 << sz) - 1);
      run(w, sz, u, a, {$urandom, $urandom}, $urandom_range(0, 3), g, e);
    end

    run0(1'b1, 2'd3, 1'b0, 64'h8, 64'hCAFEBABE12345678, 64'd0, 1'b0);
    run0(1'b0, 2'd3, 1'b0, 64'h8, 64'd0, 64'hCAFEBABE12345678, 1'b0);
    run0(1'b0, 2'd1, 1'b0, 64'hE, 64'd0, 64'hFFFFFFFFFFFFCAFE, 1'b0);
    run0(1'b0, 2'd1, 1'b1, 64'hE, 64'd0, 64'h000000000000CAFE, 1'b0);
    run0(1'b1, 2'd2, 1'b0, 64'h7C, 64'h0000000087654321, 64'd0, 1'b0);
    run0(1'b0, 2'd2, 1'b1, 64'h7C, 64'd0, 64'h0000000087654321, 1'b0);
    run0(1'b0, 2'd3, 1'b0, 64'(DEPTH0*8), 64'd0, 64'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
